pcie_wr_ram: RTL and testbench

PCIE_WR_RAM -- requirements
Module: pcie_wr_ram

---
 rtl/pcie_wr_ram_pkg.sv | 28 ++
 rtl/wr_addr_fifo.sv | 59 +++++
 rtl/pcie_wr_ram.sv | 140 ++++++++++++++
 tb/tb_pcie_wr_ram.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_wr_ram_pkg.sv
// Shared definitions for the DMA write-to-RAM path: FSM encoding, address
// field positions, line geometry and the beat word-swap helper.
package pcie_wr_ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COLLECT,
    S_WRITE
  } wr_state_t;

  localparam int unsigned ADDR_SEL_BIT   = 17;
  localparam int unsigned LINE_LSB       = 6;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned OTT_AW         = 11;
  localparam int unsigned DVB_AW         = 6;

  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned LINE_W     = BEAT_W * BEATS_PER_LINE;
  localparam int unsigned AQ_W       = ADDR_SEL_BIT - LINE_LSB + 1;
  localparam int unsigned BEAT_CNT_W = $clog2(BEATS_PER_LINE);

  // The read path emits the upper host word first, so writes swap halves back.
  function automatic logic [BEAT_W-1:0] swap_words(input logic [BEAT_W-1:0] beat);
    return {beat[BEAT_W/2-1:0], beat[BEAT_W-1:BEAT_W/2]};
  endfunction

endpackage

// File: rtl/wr_addr_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending line addresses.
// Pushes while full are dropped; the caller flags that as an error.
module wr_addr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_wr_ram.sv
// Collects eight 64-bit DMA beats per queued line address and writes the
// assembled 512-bit line into either the ott or the dvb RAM.
module pcie_wr_ram
  import pcie_wr_ram_pkg::*;
#(
  parameter int unsigned AQ_DEPTH   = 16,
  parameter int unsigned AQ_BUSY_TH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_waddr_en,
  input  logic [31:0]       dma_waddr,
  input  logic              dma_wdata_en,
  input  logic [63:0]       dma_wdata,
  output logic              dma_wdata_rdy,
  output logic              dma_waddr_busy,
  output logic              ott_wea,
  output logic [OTT_AW-1:0] ott_waddr,
  output logic [LINE_W-1:0] ott_dina,
  output logic              dvb_wea,
  output logic [DVB_AW-1:0] dvb_waddr,
  output logic [LINE_W-1:0] dvb_dina,
  output logic              wr_err
);

  localparam int unsigned AQ_CW = $clog2(AQ_DEPTH + 1);

  wr_state_t             state;
  logic [AQ_W-1:0]       aq_din;
  logic [AQ_W-1:0]       aq_dout;
  logic                  aq_pop;
  logic                  aq_empty;
  logic                  aq_full;
  logic [AQ_CW-1:0]      aq_count;
  logic [AQ_W-1:0]       line_addr;
  logic [BEAT_CNT_W-1:0] beat_k;
  logic [LINE_W-1:0]     line;
  logic [LINE_W-1:0]     line_nxt;
  logic                  beat_take;
  logic                  beat_drop;
  logic                  push_drop;
  logic                  last_beat;
  logic                  unused_addr_bits;

  assign aq_din           = dma_waddr[ADDR_SEL_BIT:LINE_LSB];
  assign unused_addr_bits = ^{dma_waddr[31:ADDR_SEL_BIT+1], dma_waddr[LINE_LSB-1:0]};

  wr_addr_fifo #(
    .DEPTH (AQ_DEPTH),
    .WIDTH (AQ_W)
  ) u_wr_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dma_waddr_en),
    .din   (aq_din),
    .pop   (aq_pop),
    .dout  (aq_dout),
    .empty (aq_empty),
    .full  (aq_full),
    .count (aq_count)
  );

  assign dma_wdata_rdy = (state == S_COLLECT) && !rst;
  assign aq_pop        = (state == S_LOAD);
  assign beat_take     = dma_wdata_en && dma_wdata_rdy;
  assign beat_drop     = dma_wdata_en && !dma_wdata_rdy;
  assign push_drop     = dma_waddr_en && aq_full;
  assign last_beat     = beat_take && (beat_k == BEAT_CNT_W'(BEATS_PER_LINE - 1));

  // The last beat is merged combinationally so the RAM outputs can be
  // registered on the same edge that accepts it.
  always_comb begin
    line_nxt = line;
    line_nxt[{beat_k, 6'd0} +: BEAT_W] = swap_words(dma_wdata);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      line_addr      <= '0;
      beat_k         <= '0;
      line           <= '0;
      wr_err         <= 1'b0;
      dma_waddr_busy <= 1'b0;
      ott_wea        <= 1'b0;
      ott_waddr      <= '0;
      ott_dina       <= '0;
      dvb_wea        <= 1'b0;
      dvb_waddr      <= '0;
      dvb_dina       <= '0;
    end else begin
      ott_wea        <= 1'b0;
      ott_waddr      <= '0;
      ott_dina       <= '0;
      dvb_wea        <= 1'b0;
      dvb_waddr      <= '0;
      dvb_dina       <= '0;
      dma_waddr_busy <= (aq_count >= AQ_CW'(AQ_BUSY_TH));
      if (push_drop || beat_drop) begin
        wr_err <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (!aq_empty) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          line_addr <= aq_dout;
          beat_k    <= '0;
          state     <= S_COLLECT;
        end
        S_COLLECT: begin
          if (beat_take) begin
            line   <= line_nxt;
            beat_k <= beat_k + 1'b1;
          end
          if (last_beat) begin
            state <= S_WRITE;
            if (line_addr[AQ_W-1]) begin
              dvb_wea   <= 1'b1;
              dvb_waddr <= line_addr[DVB_AW-1:0];
              dvb_dina  <= line_nxt;
            end else begin
              ott_wea   <= 1'b1;
              ott_waddr <= line_addr[OTT_AW-1:0];
              ott_dina  <= line_nxt;
            end
          end
        end
        S_WRITE: begin
          state <= aq_empty ? S_IDLE : S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_wr_ram.sv
// Directed bench for pcie_wr_ram: queued line addresses, beat packing,
// RAM select, busy threshold, error flag and reset behaviour.
module tb_pcie_wr_ram;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dma_waddr_en = 1'b0;
  logic [31:0]  dma_waddr = '0;
  logic         dma_wdata_en = 1'b0;
  logic [63:0]  dma_wdata = '0;
  logic         dma_wdata_rdy;
  logic         dma_waddr_busy;
  logic         ott_wea;
  logic [10:0]  ott_waddr;
  logic [511:0] ott_dina;
  logic         dvb_wea;
  logic [5:0]   dvb_waddr;
  logic [511:0] dvb_dina;
  logic         wr_err;

  pcie_wr_ram #(
    .AQ_DEPTH   (16),
    .AQ_BUSY_TH (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dma_waddr_en   (dma_waddr_en),
    .dma_waddr      (dma_waddr),
    .dma_wdata_en   (dma_wdata_en),
    .dma_wdata      (dma_wdata),
    .dma_wdata_rdy  (dma_wdata_rdy),
    .dma_waddr_busy (dma_waddr_busy),
    .ott_wea        (ott_wea),
    .ott_waddr      (ott_waddr),
    .ott_dina       (ott_dina),
    .dvb_wea        (dvb_wea),
    .dvb_waddr      (dvb_waddr),
    .dvb_dina       (dvb_dina),
    .wr_err         (wr_err)
  );

  always #5 clk = ~clk;

  int unsigned  n_vec    = 0;
  int unsigned  n_err    = 0;
  int unsigned  cyc      = 0;
  int unsigned  bad_idle = 0;
  int unsigned  last_cyc = 0;
  int unsigned  ev_cyc[$];
  logic         ev_dvb[$];
  logic [10:0]  ev_addr[$];
  logic [511:0] ev_data[$];

  always @(posedge clk) cyc++;

  // Record every RAM write; flag idle outputs that are not zero.
  always @(negedge clk) begin
    if (ott_wea === 1'b1 && dvb_wea === 1'b1) bad_idle++;
    if (ott_wea === 1'b0 && (ott_waddr !== '0 || ott_dina !== '0)) bad_idle++;
    if (dvb_wea === 1'b0 && (dvb_waddr !== '0 || dvb_dina !== '0)) bad_idle++;
    if (ott_wea === 1'b1) begin
      ev_cyc.push_back(cyc); ev_dvb.push_back(1'b0);
      ev_addr.push_back(ott_waddr); ev_data.push_back(ott_dina);
    end
    if (dvb_wea === 1'b1) begin
      ev_cyc.push_back(cyc); ev_dvb.push_back(1'b1);
      ev_addr.push_back({5'd0, dvb_waddr}); ev_data.push_back(dvb_dina);
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    ev_cyc.delete(); ev_dvb.delete(); ev_addr.delete(); ev_data.delete();
  endtask

  task automatic do_reset();
    clear_ev();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_addr(input logic [31:0] a);
    dma_waddr    = a;
    dma_waddr_en = 1'b1;
    tick();
    dma_waddr_en = 1'b0;
  endtask

  // Beat i of test line l; line 0 is 0x11111111_22222222 .. 0x88888888_99999999.
  function automatic logic [63:0] beat_of(input int unsigned l, input int unsigned i);
    logic [31:0] hi, lo;
    hi = (32'h11111111 * (i + 1)) ^ (l << 20);
    lo = (32'h11111111 * (i + 2)) ^ (l << 20);
    return {hi, lo};
  endfunction

  function automatic logic [511:0] exp_line(input int unsigned l);
    logic [511:0] r;
    logic [63:0]  b;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b = beat_of(l, i);
      r[64*i +: 32]    = b[63:32];
      r[64*i+32 +: 32] = b[31:0];
    end
    return r;
  endfunction

  task automatic send_line(input int unsigned l, input int unsigned n);
    int unsigned i = 0;
    int unsigned guard = 0;
    while (i < n && guard < 200) begin
      if (dma_wdata_rdy) begin
        dma_wdata_en = 1'b1;
        dma_wdata    = beat_of(l, i);
        last_cyc     = cyc;
        i++;
      end else begin
        dma_wdata_en = 1'b0;
      end
      tick();
      guard++;
    end
    dma_wdata_en = 1'b0;
    if (i < n) chk("rdy_timeout", i, n);
  endtask

  task automatic wait_events(input int unsigned n);
    int unsigned guard = 0;
    while (ev_cyc.size() < n && guard < 200) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("write_count", ev_cyc.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_rdy", dma_wdata_rdy, 1'b0);
    chk("rst_busy", dma_waddr_busy, 1'b0);
    chk("rst_ott_wea", ott_wea, 1'b0);
    chk("rst_dvb_wea", dvb_wea, 1'b0);
    chk("rst_ott_waddr", ott_waddr, 11'd0);
    chk("rst_dvb_dina", dvb_dina, 512'd0);
    chk("rst_err", wr_err, 1'b0);
    rst = 1'b0;
    tick();

    // Line 1 into ott
    clear_ev();
    push_addr(32'h0000_0040);
    send_line(0, 8);
    wait_events(1);
    chk("ott_sel", ev_dvb[0], 1'b0);
    chk("ott_addr", ev_addr[0], 11'd1);
    chk("ott_w0", ev_data[0][31:0], 32'h11111111);
    chk("ott_w1", ev_data[0][63:32], 32'h22222222);
    chk("ott_w15", ev_data[0][511:480], 32'h99999999);
    chk("ott_line", ev_data[0], exp_line(0));
    chk("ott_latency", ev_cyc[0], last_cyc + 1);
    chk("ott_no_err", wr_err, 1'b0);

    // Line 63 into dvb
    clear_ev();
    push_addr(32'h0002_0FC0);
    send_line(1, 8);
    wait_events(1);
    chk("dvb_sel", ev_dvb[0], 1'b1);
    chk("dvb_addr", ev_addr[0], 11'd63);
    chk("dvb_line", ev_data[0], exp_line(1));

    // Data beat while idle
    clear_ev();
    dma_wdata    = 64'hDEAD_BEEF_0123_4567;
    dma_wdata_en = 1'b1;
    tick();
    dma_wdata_en = 1'b0;
    tick();
    chk("idle_beat_err", wr_err, 1'b1);
    repeat (5) tick();
    chk("idle_beat_no_write", ev_cyc.size(), 0);
    chk("err_sticky", wr_err, 1'b1);
    do_reset();
    chk("err_cleared", wr_err, 1'b0);

    // Reset mid-collect discards the partial line
    push_addr(32'h0000_0080);
    send_line(3, 4);
    do_reset();
    repeat (4) tick();
    chk("partial_no_write", ev_cyc.size(), 0);
    chk("partial_rdy_idle", dma_wdata_rdy, 1'b0);
    push_addr(32'h0000_00C0);
    send_line(5, 8);
    wait_events(1);
    chk("after_rst_addr", ev_addr[0], 11'd3);
    chk("after_rst_line", ev_data[0], exp_line(5));

    // Two queued lines, second push coincides with the first pop
    do_reset();
    push_addr(32'h0000_0100);
    tick();
    push_addr(32'h0002_0140);
    send_line(6, 8);
    send_line(7, 8);
    wait_events(2);
    chk("pair_gap", ev_cyc[1] - ev_cyc[0], 10);
    chk("pair0_sel", ev_dvb[0], 1'b0);
    chk("pair0_addr", ev_addr[0], 11'd4);
    chk("pair0_line", ev_data[0], exp_line(6));
    chk("pair1_sel", ev_dvb[1], 1'b1);
    chk("pair1_addr", ev_addr[1], 11'd5);
    chk("pair1_line", ev_data[1], exp_line(7));

    // Fill the queue behind a line that is waiting for data
    do_reset();
    push_addr(32'h0000_1000);
    begin
      int unsigned guard = 0;
      while (!dma_wdata_rdy && guard < 20) begin
        tick();
        guard++;
      end
      chk("fill_collect", dma_wdata_rdy, 1'b1);
    end
    for (int j = 1; j <= 16; j++) begin
      push_addr(32'((40 + j - 1) << 6));
      if (j == 11 || j == 12) chk($sformatf("busy_low_%0d", j), dma_waddr_busy, 1'b0);
      if (j == 13) chk("busy_high_13", dma_waddr_busy, 1'b1);
    end
    chk("full_no_err", wr_err, 1'b0);
    chk("full_busy", dma_waddr_busy, 1'b1);
    push_addr(32'(99 << 6));
    chk("overflow_err", wr_err, 1'b1);
    for (int j = 0; j <= 16; j++) send_line(20 + j, 8);
    wait_events(17);
    chk("fill_first_addr", ev_addr[0], 11'd64);
    chk("fill_first_line", ev_data[0], exp_line(20));
    for (int j = 1; j <= 16; j++) begin
      chk($sformatf("fill_order_%0d", j), ev_addr[j], 11'(40 + j - 1));
    end
    chk("fill_last_line", ev_data[16], exp_line(36));
    chk("drained_busy", dma_waddr_busy, 1'b0);
    chk("drained_err_sticky", wr_err, 1'b1);

    chk("idle_outputs_zero", bad_idle, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
